nor_chain_test_sequencer: RTL and testbench



---
 rtl/nor_tester_pkg.sv | 18 +
 rtl/nor_chain_test_sequencer_if.sv | 37 +++
 rtl/nor_chain_expect.sv | 19 +
 rtl/nor_chain_test_sequencer.sv | 139 +++++++++++++
 tb/tb_nor_chain_test_sequencer.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/nor_tester_pkg.sv
// nor_tester_pkg
//   Shared types and constants for the NOR chain test sequencer:
//   FSM state encoding, number of exhaustive input vectors, and the
//   settle-counter width sized for the largest legal SETTLE_CYCLES.
package nor_tester_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        CHECK  = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam int unsigned NUM_VEC    = 8;
    localparam int unsigned SETTLE_MAX = 15;
    localparam int unsigned CNT_W      = $clog2(SETTLE_MAX + 1);

endpackage

// File: rtl/nor_chain_test_sequencer_if.sv
// nor_chain_test_sequencer_if
//   Bundles the host control/status signals and the datapath drive/sense
//   signals of the NOR chain test sequencer.
//   Host side   : start, abort -> busy, done, pass, err_count,
//                 first_fail_vec, first_fail_valid
//   Datapath    : drv_a/b/c -> NOR chain, sns_d/sns_e <- NOR chain
//   slave  modport : the sequencer
//   master modport : host plus the datapath under exercise
interface nor_chain_test_sequencer_if;

    logic       start;
    logic       abort;
    logic       sns_d;
    logic       sns_e;
    logic       drv_a;
    logic       drv_b;
    logic       drv_c;
    logic       busy;
    logic       done;
    logic       pass;
    logic [3:0] err_count;
    logic [2:0] first_fail_vec;
    logic       first_fail_valid;

    modport slave (
        input  start, abort, sns_d, sns_e,
        output drv_a, drv_b, drv_c, busy, done, pass,
               err_count, first_fail_vec, first_fail_valid
    );

    modport master (
        output start, abort, sns_d, sns_e,
        input  drv_a, drv_b, drv_c, busy, done, pass,
               err_count, first_fail_vec, first_fail_valid
    );

endinterface

// File: rtl/nor_chain_expect.sv
// nor_chain_expect
//   Combinational reference of the two-stage NOR chain.
//   a, b, c : datapath inputs
//   exp_d   : ~(a | b)
//   exp_e   : ~(c | exp_d)
module nor_chain_expect (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic exp_d,
    output logic exp_e
);

    always_comb begin
        exp_d = ~(a | b);
        exp_e = ~(c | exp_d);
    end

endmodule

// File: rtl/nor_chain_test_sequencer.sv
// nor_chain_test_sequencer
//   Walks all eight {a,b,c} vectors into a NOR chain datapath, holds each
//   for SETTLE_CYCLES cycles, samples d/e once and compares them with the
//   reference model. Reports pass, mismatch count and first failing vector.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : control/status and datapath drive/sense (slave modport)
//   SETTLE_CYCLES : hold cycles per vector before sampling, 1..15
module nor_chain_test_sequencer
    import nor_tester_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    nor_chain_test_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [2:0]       IDX_LAST = 3'(NUM_VEC - 1);

    state_t           state_q, state_d;
    logic [2:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       err_q, err_d;
    logic [2:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;
    logic             pass_q, pass_d;

    logic             exp_d;
    logic             exp_e;
    logic             mismatch;
    logic             busy;

    nor_chain_expect u_expect (
        .a     (idx_q[2]),
        .b     (idx_q[1]),
        .c     (idx_q[0]),
        .exp_d (exp_d),
        .exp_e (exp_e)
    );

    assign mismatch = (bus.sns_d != exp_d) || (bus.sns_e != exp_e);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            pass_q    <= pass_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        pass_d    = pass_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    state_d   = SETTLE;
                    idx_d     = '0;
                    cnt_d     = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            SETTLE: begin
                if (bus.abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = CHECK;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            CHECK: begin
                // Abort takes priority: the sample of an aborted CHECK cycle is dropped.
                if (bus.abort) begin
                    state_d = IDLE;
                    pass_d  = 1'b0;
                end else begin
                    if (mismatch) begin
                        err_d = err_q + 4'd1;
                        if (!ffvalid_q) begin
                            ffvalid_d = 1'b1;
                            ffv_d     = idx_q;
                        end
                    end
                    if (idx_q == IDX_LAST) begin
                        state_d = DONE;
                        // Uses err_d so the final vector's result counts.
                        pass_d  = (err_d == '0);
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = '0;
                        state_d = SETTLE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        busy     = (state_q == SETTLE) || (state_q == CHECK);
        bus.busy = busy;
        bus.done = (state_q == DONE);
        {bus.drv_a, bus.drv_b, bus.drv_c} = busy ? idx_q : 3'b000;
    end

    assign bus.pass             = pass_q;
    assign bus.err_count        = err_q;
    assign bus.first_fail_vec   = ffv_q;
    assign bus.first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_nor_chain_test_sequencer.sv
module tb_nor_chain_test_sequencer;

    localparam int S = 2;
    localparam int P = S + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    nor_chain_test_sequencer_if bus();

    nor_chain_test_sequencer #(.SETTLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   mode       = 0;   // 0 golden chain, 1 sns_e stuck 0, 2 sns_d stuck 1
    int   vectors    = 0;
    int   miscompares = 0;
    int   done_cnt   = 0;
    logic chk_en     = 1'b0;
    int   seq[$];

    // Datapath as seen by the sequencer, including the planted faults.
    function automatic logic [1:0] datapath(input int md, input logic [2:0] v);
        logic d, e;
        d = ~(v[2] | v[1]);
        if (md == 2) d = 1'b1;
        e = ~(v[0] | d);
        if (md == 1) e = 1'b0;
        return {d, e};
    endfunction

    always_comb {bus.sns_d, bus.sns_e} = datapath(mode, {bus.drv_a, bus.drv_b, bus.drv_c});

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [13:0] pack_out();
        return {bus.busy, bus.done, bus.pass, bus.err_count, bus.first_fail_valid,
                bus.first_fail_vec, bus.drv_a, bus.drv_b, bus.drv_c};
    endfunction

    // Behavioural model: time since the accepting edge decides everything.
    bit         m_active, m_done, m_pass, m_ffvalid;
    int         m_t, m_err;
    logic [2:0] m_ffv;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_active = 0; m_done = 0; m_pass = 0; m_ffvalid = 0;
            m_t = 0; m_err = 0; m_ffv = 3'd0;
        end else begin : model_step
            bit was_done;
            int v;
            was_done = m_done;
            m_done   = 0;
            if (m_active) begin
                if (bus.abort) begin
                    m_active = 0;
                    m_pass   = 0;
                end else begin
                    if (m_t % P == S) begin
                        v = m_t / P;
                        if (datapath(mode, 3'(v)) != datapath(0, 3'(v))) begin
                            m_err++;
                            if (!m_ffvalid) begin
                                m_ffvalid = 1;
                                m_ffv     = 3'(v);
                            end
                        end
                    end
                    m_t++;
                    if (m_t == 8 * P) begin
                        m_active = 0;
                        m_done   = 1;
                        m_pass   = (m_err == 0);
                    end
                end
            end else if (!was_done && bus.start && !bus.abort) begin
                m_active = 1; m_t = 0; m_err = 0;
                m_ffvalid = 0; m_ffv = 3'd0; m_pass = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && chk_en) begin : compare
            logic [2:0]  edrv;
            logic [13:0] exp;
            logic [2:0]  drv;
            edrv = m_active ? 3'(m_t / P) : 3'd0;
            exp  = {m_active, m_done, m_pass, 4'(m_err), m_ffvalid, m_ffv, edrv};
            chk("cycle_model", 32'(pack_out()), 32'(exp));
            drv = {bus.drv_a, bus.drv_b, bus.drv_c};
            if (bus.done) done_cnt++;
            if (bus.busy && (seq.size() == 0 || seq[$] != int'(drv))) seq.push_back(int'(drv));
        end
    end

    // Pulses start at a negedge and counts rising edges from the accepting edge to done.
    task automatic run(input bit repulse, output int edges);
        bus.start = 1'b1;
        @(posedge clk);
        edges = 0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            bus.start = repulse && (edges == 4 || edges == 10);
            if (bus.done) break;
        end
        bus.start = 1'b0;
    endtask

    task automatic wait_drv(input logic [2:0] v);
        for (int i = 0; i < 100; i++) begin
            if (bus.busy && {bus.drv_a, bus.drv_b, bus.drv_c} == v) break;
            @(negedge clk);
        end
        chk("wait_drv_reached", 32'({bus.drv_a, bus.drv_b, bus.drv_c}), 32'(v));
    endtask

    initial begin : main
        int          edges;
        int          d0;
        logic [23:0] seqpack;
        bus.start = 1'b0;
        bus.abort = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", 32'(pack_out()), 32'd0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
        @(negedge clk);

        // Golden chain
        mode = 0;
        seq.delete();
        run(1'b0, edges);
        chk("golden_latency", edges, 24);
        chk("golden_pass", bus.pass, 1);
        chk("golden_err", bus.err_count, 0);
        chk("golden_ffvalid", bus.first_fail_valid, 0);
        seqpack = '0;
        foreach (seq[i]) seqpack = {seqpack[20:0], 3'(seq[i])};
        chk("drv_seq_len", seq.size(), 8);
        chk("drv_sequence", seqpack, 24'h053977);
        @(negedge clk);

        // sns_e stuck at 0
        mode = 1;
        run(1'b0, edges);
        chk("e0_latency", edges, 24);
        chk("e0_err", bus.err_count, 3);
        chk("e0_ffv", bus.first_fail_vec, 2);
        chk("e0_ffvalid", bus.first_fail_valid, 1);
        chk("e0_pass", bus.pass, 0);
        @(negedge clk);

        // sns_d stuck at 1
        mode = 2;
        run(1'b0, edges);
        chk("d1_err", bus.err_count, 6);
        chk("d1_ffv", bus.first_fail_vec, 2);
        chk("d1_pass", bus.pass, 0);
        @(negedge clk);

        // Abort during vector 3 (one mismatch already recorded at vector 2)
        mode = 1;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drv(3'd3);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("abort_busy", bus.busy, 0);
        chk("abort_drv", 32'({bus.drv_a, bus.drv_b, bus.drv_c}), 0);
        chk("abort_err", bus.err_count, 1);
        chk("abort_ffv", bus.first_fail_vec, 2);
        chk("abort_pass", bus.pass, 0);
        d0 = done_cnt;
        repeat (30) @(negedge clk);
        chk("abort_no_done", done_cnt - d0, 0);

        // start+abort in IDLE ignored; start re-pulsed while busy and in DONE ignored
        mode = 0;
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("start_abort_idle", bus.busy, 0);
        d0 = done_cnt;
        run(1'b1, edges);
        chk("repulse_latency", edges, 24);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("start_in_done", bus.busy, 0);
        chk("single_done", done_cnt - d0, 1);
        chk("repulse_pass", bus.pass, 1);

        // Asynchronous reset mid-run, then a fresh run
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_drv(3'd5);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", 32'(pack_out()), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run(1'b0, edges);
        chk("post_reset_latency", edges, 24);
        chk("post_reset_pass", bus.pass, 1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
